// File: rtl/uart_tx_fifo.sv
// Purpose: byte FIFO feeding an 8N1/8N2 serialiser; frames leave back-to-back while bytes are queued.
// Latency: byte strobed at edge N into an idle, empty block -> count=1 after N, tx falls after N+1.
// Backpressure: writes while full are dropped and flagged by a one-cycle overflow pulse.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous reset, active low
//   tx_send   byte to enqueue
//   tx_ready  write strobe; byte taken when full=0
//   tx        serial line, idle high
//   busy      high from start bit through last stop bit
//   full      occupancy == DEPTH
//   empty     occupancy == 0
//   count     occupancy, 0..DEPTH
//   overflow  one-cycle pulse for a strobe that arrived while full
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 35,
    parameter int ADDR_W       = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        tx_send,
    input  logic              tx_ready,
    output logic              tx,
    output logic              busy,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    localparam int DEPTH     = 1 << ADDR_W;
    localparam int STOP_CLKS = CLKS_PER_BIT * STOP_BITS;
    // The stop period is the longest interval timed by the baud counter.
    localparam int BAUD_W    = (STOP_CLKS > 1) ? $clog2(STOP_CLKS) : 1;

    localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] STOP_LAST = BAUD_W'(STOP_CLKS - 1);
    localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // ---------------------------------------------------------------
    // FIFO storage and pointers
    // ---------------------------------------------------------------
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_n;
    logic              wr_en;
    logic              pop;
    logic [7:0]        head;

    // Acceptance is judged on the registered (pre-edge) full flag.
    assign wr_en = tx_ready & ~full;
    assign head  = mem[rd_ptr];

    // Storage needs no reset: entries are only read once count says they are valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= tx_send;
        end
    end

    always_comb begin
        count_n = count;
        case ({wr_en, pop})
            2'b10:   count_n = count + 1'b1;
            2'b01:   count_n = count - 1'b1;
            default: count_n = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count    <= count_n;
            full     <= (count_n == FULL_CNT);
            empty    <= (count_n == '0);
            overflow <= tx_ready & full;
        end
    end

    // ---------------------------------------------------------------
    // Serialiser
    // ---------------------------------------------------------------
    state_t            state_q, state_n;
    logic [BAUD_W-1:0] baud_q,  baud_n;
    logic [2:0]        bit_q,   bit_n;
    logic [7:0]        shift_q, shift_n;
    logic              tx_n;
    logic              busy_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state_q <= state_n;
            baud_q  <= baud_n;
            bit_q   <= bit_n;
            shift_q <= shift_n;
            tx      <= tx_n;
            busy    <= busy_n;
        end
    end

    // tx/busy are computed one cycle ahead so the line itself is a flop.
    always_comb begin
        state_n = state_q;
        baud_n  = baud_q;
        bit_n   = bit_q;
        shift_n = shift_q;
        tx_n    = tx;
        busy_n  = busy;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                tx_n   = 1'b1;
                busy_n = 1'b0;
                // Uses registered empty, so a byte written this cycle waits one clock.
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = head;
                    state_n = START;
                    tx_n    = 1'b0;
                    busy_n  = 1'b1;
                    baud_n  = '0;
                end
            end

            START: begin
                if (baud_q == BIT_LAST) begin
                    state_n = DATA;
                    baud_n  = '0;
                    bit_n   = '0;
                    tx_n    = shift_q[0];
                end else begin
                    baud_n = baud_q + BAUD_W'(1);
                end
            end

            DATA: begin
                if (baud_q == BIT_LAST) begin
                    baud_n = '0;
                    if (bit_q == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_n   = bit_q + 3'd1;
                        shift_n = {1'b0, shift_q[7:1]};
                        tx_n    = shift_q[1];
                    end
                end else begin
                    baud_n = baud_q + BAUD_W'(1);
                end
            end

            STOP: begin
                if (baud_q == STOP_LAST) begin
                    baud_n = '0;
                    if (!empty) begin
                        // Chain straight into the next start bit: no idle gap.
                        pop     = 1'b1;
                        shift_n = head;
                        state_n = START;
                        tx_n    = 1'b0;
                    end else begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                    end
                end else begin
                    baud_n = baud_q + BAUD_W'(1);
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Purpose: randomized scoreboard bench for uart_tx_fifo (1 and 2 stop-bit instances).
// Latency: reference model predicts pop time of every accepted byte from frame arithmetic.
// Backpressure: bursts drive the FIFO full to exercise overflow drops.
module tb_uart_tx_fifo;

    localparam int CPB   = 35;
    localparam int DEPTH = 16;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_send;
    logic       tx_ready;
    logic       tx, busy, full, empty, overflow;
    logic [4:0] count;

    logic [7:0] tx_send2;
    logic       tx_ready2;
    logic       tx2, busy2, full2, empty2, overflow2;
    logic [4:0] count2;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .ADDR_W(4), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .tx_send(tx_send), .tx_ready(tx_ready),
        .tx(tx), .busy(busy), .full(full), .empty(empty),
        .count(count), .overflow(overflow)
    );

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .ADDR_W(4), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .tx_send(tx_send2), .tx_ready(tx_ready2),
        .tx(tx2), .busy(busy2), .full(full2), .empty(empty2),
        .count(count2), .overflow(overflow2)
    );

    // ---------------------------------------------------------------
    // Reference model: each accepted byte is scheduled to leave at
    // max(accept+1, previous departure + FRAME). Occupancy is
    // accepted minus departed; busy covers FRAME cycles from a departure.
    // ---------------------------------------------------------------
    typedef struct {
        logic [7:0] b;
        int         t;
    } exp_t;

    exp_t exp_q[$];
    int   pend[$];
    int   cyc        = 0;
    int   model_cnt  = 0;
    int   last_sched = -1000000;
    int   cur_pop    = -1000000;
    int   m_pt;
    logic exp_busy   = 1'b0;
    logic exp_ovf    = 1'b0;
    int   exp_cnt    = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend.delete();
            model_cnt  = 0;
            last_sched = -1000000;
            cur_pop    = -1000000;
            exp_busy   = 1'b0;
            exp_ovf    = 1'b0;
            exp_cnt    = 0;
        end else begin
            cyc++;
            exp_ovf = tx_ready && (model_cnt == DEPTH);
            if (tx_ready && model_cnt < DEPTH) begin
                m_pt = (cyc + 1 > last_sched + FRAME) ? cyc + 1 : last_sched + FRAME;
                last_sched = m_pt;
                pend.push_back(m_pt);
                exp_q.push_back('{b: tx_send, t: m_pt});
                model_cnt++;
            end
            while (pend.size() > 0 && pend[0] == cyc) begin
                void'(pend.pop_front());
                model_cnt--;
                cur_pop = cyc;
            end
            exp_busy = (cyc >= cur_pop) && (cyc < cur_pop + FRAME);
            exp_cnt  = model_cnt;
        end
    end

    // ---------------------------------------------------------------
    // Monitor / checker (sole owner of the counters)
    // ---------------------------------------------------------------
    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    int         mon_st    = 0;
    int         mon_t     = 0;
    int         mon_start = 0;
    int         mon_idx   = 0;
    int         mon_k;
    logic [7:0] mon_byte  = 8'h00;

    int   d2_exp[$];
    int   d2_i     = 0;
    int   d2_falls = 0;
    int   d2_run   = 0;
    int   d2_busy  = 0;
    logic d2_prev  = 1'b1;

    logic final_chk  = 1'b0;
    logic final_done = 1'b0;

    always @(negedge clk) begin
        chk("count",    32'(count),    32'(exp_cnt));
        chk("full",     32'(full),     32'(exp_cnt == DEPTH));
        chk("empty",    32'(empty),    32'(exp_cnt == 0));
        chk("overflow", 32'(overflow), 32'(exp_ovf));
        chk("busy",     32'(busy),     32'(exp_busy));
        if (!exp_busy) chk("tx_idle", 32'(tx), 32'd1);

        if (!rst) begin
            mon_st  = 0;
            mon_idx = exp_q.size();
            d2_prev = 1'b1;
            d2_run  = 0;
        end else begin
            if (mon_st == 0) begin
                if (tx == 1'b0) begin
                    mon_st    = 1;
                    mon_t     = 0;
                    mon_start = cyc;
                    mon_byte  = 8'h00;
                end
            end else begin
                mon_t++;
            end
            if (mon_st == 1 && (mon_t % CPB) == CPB / 2) begin
                mon_k = mon_t / CPB;
                if (mon_k == 0) begin
                    chk("start_bit", 32'(tx), 32'd0);
                end else if (mon_k <= 8) begin
                    mon_byte[mon_k-1] = tx;
                end else begin
                    chk("stop_bit", 32'(tx), 32'd1);
                    if (mon_idx < exp_q.size()) begin
                        chk("frame_byte",  32'(mon_byte),  32'(exp_q[mon_idx].b));
                        chk("frame_start", 32'(mon_start), 32'(exp_q[mon_idx].t));
                        mon_idx++;
                    end else begin
                        vectors++;
                        miscompares++;
                        $display("FAIL extra_frame: got byte %0h with none expected (cycle %0d)", mon_byte, cyc);
                    end
                    mon_st = 0;
                end
            end

            // Two-stop-bit instance: high-run lengths before each falling edge.
            if (d2_prev && !tx2) begin
                if (d2_falls > 0) begin
                    if (d2_i < d2_exp.size()) begin
                        chk("stop2_run", 32'(d2_run), 32'(d2_exp[d2_i]));
                    end else begin
                        vectors++;
                        miscompares++;
                        $display("FAIL stop2_extra_edge: got run %0d with none expected", d2_run);
                    end
                    d2_i++;
                end
                d2_falls++;
            end
            d2_run  = tx2 ? d2_run + 1 : 0;
            d2_prev = tx2;
            if (busy2) d2_busy++;
        end

        if (final_chk && !final_done) begin
            chk("frames_drained", 32'(mon_idx),  32'(exp_q.size()));
            chk("stop2_edges",    32'(d2_i),     32'(d2_exp.size()));
            chk("busy2_cycles",   32'(d2_busy),  32'(2 * 11 * CPB));
            chk("count2_final",   32'(count2),   32'd0);
            chk("empty2_final",   32'(empty2),   32'd1);
            chk("full2_final",    32'(full2),    32'd0);
            chk("overflow2_final",32'(overflow2),32'd0);
            final_done = 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] b);
        tx_ready = 1'b1;
        tx_send  = b;
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
    endtask

    task automatic drain();
        int b;
        b = 0;
        while ((exp_busy || pend.size() != 0) && b < 30000) begin
            step(1);
            b++;
        end
        step(3);
    endtask

    initial begin
        logic [7:0] d2_byte;
        logic       bits[$];
        int         run;
        logic       prev;
        logic       first;

        // Expected high runs on the 8N2 line for two 0x55 frames.
        d2_byte = 8'h55;
        for (int f = 0; f < 2; f++) begin
            bits.push_back(1'b0);
            for (int i = 0; i < 8; i++) bits.push_back(d2_byte[i]);
            bits.push_back(1'b1);
            bits.push_back(1'b1);
        end
        run   = 0;
        prev  = 1'b1;
        first = 1'b1;
        foreach (bits[i]) begin
            if (prev && !bits[i]) begin
                if (!first) d2_exp.push_back(run * CPB);
                first = 1'b0;
            end
            run  = bits[i] ? run + 1 : 0;
            prev = bits[i];
        end

        tx_ready  = 1'b0;
        tx_send   = 8'h00;
        tx_ready2 = 1'b0;
        tx_send2  = 8'h00;
        rst       = 1'b1;
        #1;
        rst = 1'b0;
        step(3);
        rst = 1'b1;
        step(2);

        // Single 0x55 on the main instance; two 0x55 on the 8N2 instance.
        tx_ready2 = 1'b1;
        tx_send2  = 8'h55;
        wr(8'h55);
        step(1);
        tx_ready2 = 1'b0;
        drain();
        step(2 * 11 * CPB);

        // Back-to-back pair.
        wr(8'h55);
        wr(8'hAA);
        drain();

        // Burst of 18 into idle: last one overflows.
        for (int i = 0; i < 18; i++) wr(8'(i));
        drain();

        // Pointer wrap.
        for (int i = 0; i < 10; i++) wr(8'($urandom));
        drain();
        for (int i = 0; i < 10; i++) wr(8'hA0 + 8'(i));
        drain();

        // Random traffic alternating sparse and saturating phases.
        for (int i = 0; i < 3000; i++) begin
            tx_ready = ($urandom_range(0, 99) < (((i / 500) % 2) ? 90 : 5));
            tx_send  = 8'($urandom);
            step(1);
        end
        tx_ready = 1'b0;
        drain();

        // Reset in the middle of data bit 4 with three bytes queued.
        wr(8'hD9);
        wr(8'h11);
        wr(8'h22);
        wr(8'h33);
        repeat (1 + 5 * CPB + CPB / 2 - 3) @(posedge clk);
        #3;
        rst = 1'b0;
        step(3);
        rst = 1'b1;
        step(2 * FRAME);
        wr(8'h32);
        drain();

        final_chk = 1'b1;
        step(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
